// File: rtl/key_event_arbiter_if.sv
// Event-side bundle of key_event_arbiter: key pulses in, queued events and status out.
// master = arbiter, slave = key scanner / consumer side.
interface key_event_arbiter_if #(
  parameter int unsigned NKEYS      = 6,
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NKEYS-1:0]  key_flag;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;
  logic [NKEYS-1:0]  pend;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              ovf;
  logic              ovf_clr;

  modport master (
    input  key_flag, evt_ready, ovf_clr,
    output evt_valid, evt_code, pend, fifo_cnt, ovf
  );

  modport slave (
    output key_flag, evt_ready, ovf_clr,
    input  evt_valid, evt_code, pend, fifo_cnt, ovf
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Latches key-press pulses, arbitrates one key per cycle into a small event FIFO.
// Define KEY_ARB_RR_EN for round-robin grant; default is fixed lowest-index priority.
module key_event_arbiter #(
  parameter int unsigned NKEYS      = 6,
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_event_arbiter_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [CODE_W-1:0] code_t;

  code_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NKEYS-1:0]  pend_q, pend_d, gnt_oh;
  logic              ovf_q, ovf_d;
  logic              gnt, pop;
  code_t             gnt_idx;

  function automatic code_t lowest(input logic [NKEYS-1:0] v);
    lowest = '0;
    for (int unsigned k = NKEYS; k > 0; k--) begin
      if (v[k-1]) lowest = CODE_W'(k - 1);
    end
  endfunction

  // cnt_q never exceeds FIFO_DEPTH, so "not equal" is the "not full" test
  assign gnt = (pend_q != '0) && (cnt_q != CNT_W'(FIFO_DEPTH));
  assign pop = (cnt_q != '0) && bus.evt_ready;

`ifdef KEY_ARB_RR_EN
  code_t            rr_ptr_q;
  logic [NKEYS-1:0] hi_mask, pend_hi;

  // Keys at or above rr_ptr take precedence; fall back to the lowest overall to wrap
  always_comb begin
    hi_mask = ~((NKEYS'(1) << rr_ptr_q) - NKEYS'(1));
    pend_hi = pend_q & hi_mask;
    gnt_idx = (pend_hi != '0) ? lowest(pend_hi) : lowest(pend_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (gnt) begin
      rr_ptr_q <= (gnt_idx == CODE_W'(NKEYS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_idx = lowest(pend_q);
  end
`endif

  assign gnt_oh = gnt ? (NKEYS'(1) << gnt_idx) : '0;

  always_comb begin
    pend_d = (pend_q & ~gnt_oh) | bus.key_flag;
    ovf_d  = ovf_q;
    if (bus.ovf_clr) ovf_d = 1'b0;
    if ((bus.key_flag & pend_q & ~gnt_oh) != '0) ovf_d = 1'b1;
    cnt_d = cnt_q;
    case ({gnt, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      if (gnt) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (gnt) begin
      mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign bus.evt_valid = (cnt_q != '0);
  assign bus.evt_code  = mem_q[rd_ptr_q];
  assign bus.pend      = pend_q;
  assign bus.fifo_cnt  = cnt_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: directed scenarios push expected codes,
// a negedge monitor pops and compares on every accepted event.
module tb_key_event_arbiter;
  logic clk;
  logic rst_n;
  int unsigned tests;
  int unsigned fails;
  logic [2:0] exp_q [$];

  key_event_arbiter_if #(.NKEYS(6), .CODE_W(3), .FIFO_DEPTH(4)) bus ();

  key_event_arbiter #(.NKEYS(6), .CODE_W(3), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL evt_unexpected: got code %0d, required no event", bus.evt_code);
      end else begin
        logic [2:0] exp;
        exp = exp_q.pop_front();
        if (bus.evt_code !== exp) begin
          fails++;
          $display("FAIL evt_code: got %0d, required %0d", bus.evt_code, exp);
        end
      end
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain(input int unsigned bound);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.key_flag  = '0;
    bus.evt_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic single_press(input string tag);
    bus.evt_ready = 1'b1;
    bus.key_flag  = 6'b000100;
    exp_q.push_back(3'd2);
    step(1);
    bus.key_flag = '0;
    chk({tag, "_pend_t1"}, bus.pend, 6'b000100);
    chk({tag, "_valid_t1"}, bus.evt_valid, 1'b0);
    step(1);
    chk({tag, "_valid_t2"}, bus.evt_valid, 1'b1);
    chk({tag, "_code_t2"}, bus.evt_code, 3'd2);
    chk({tag, "_pend_t2"}, bus.pend, 6'b000000);
    step(1);
    chk({tag, "_valid_t3"}, bus.evt_valid, 1'b0);
    chk({tag, "_cnt_t3"}, bus.fifo_cnt, 3'd0);
    chk({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    do_reset();
    chk("rst_valid", bus.evt_valid, 1'b0);
    chk("rst_code", bus.evt_code, 3'd0);
    chk("rst_cnt", bus.fifo_cnt, 3'd0);
    chk("rst_pend", bus.pend, 6'd0);
    chk("rst_ovf", bus.ovf, 1'b0);

    single_press("s1");

    // all six keys at once, consumer stalled
    do_reset();
    bus.key_flag = 6'h3F;
    step(1);
    bus.key_flag = '0;
    step(4);
    chk("s2_cnt_full", bus.fifo_cnt, 3'd4);
    chk("s2_pend", bus.pend, 6'b110000);
    chk("s2_head", bus.evt_code, 3'd0);
    for (int i = 0; i < 6; i++) exp_q.push_back(3'(i));
    bus.evt_ready = 1'b1;
    drain(30);
    step(1);
    chk("s2_cnt_empty", bus.fifo_cnt, 3'd0);
    chk("s2_ovf", bus.ovf, 1'b0);

    // keys 0 and 5 hammered every cycle
    do_reset();
    bus.evt_ready = 1'b1;
`ifdef KEY_ARB_RR_EN
    for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 0) ? 3'd0 : 3'd5);
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(3'd0);
    exp_q.push_back(3'd5);
`endif
    bus.key_flag = 6'b100001;
    step(8);
    bus.key_flag = '0;
    drain(30);
    step(1);
    chk("s3_ovf", bus.ovf, 1'b1);
    chk("s3_cnt", bus.fifo_cnt, 3'd0);

    // loss while full, ovf clear and set-beats-clear
    do_reset();
    bus.key_flag = 6'b001111;
    step(1);
    bus.key_flag = '0;
    step(4);
    chk("s4_cnt_full", bus.fifo_cnt, 3'd4);
    bus.key_flag = 6'b001000;
    step(1);
    chk("s4_ovf_first", bus.ovf, 1'b0);
    step(1);
    bus.key_flag = '0;
    chk("s4_ovf_set", bus.ovf, 1'b1);
    chk("s4_pend", bus.pend, 6'b001000);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("s4_ovf_clr", bus.ovf, 1'b0);
    bus.key_flag = 6'b001000;
    bus.ovf_clr  = 1'b1;
    step(1);
    bus.key_flag = '0;
    bus.ovf_clr  = 1'b0;
    chk("s4_ovf_set_wins", bus.ovf, 1'b1);
    chk("s4_cnt_nogrant", bus.fifo_cnt, 3'd4);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    bus.evt_ready = 1'b1;
    drain(30);
    step(1);
    chk("s4_cnt_empty", bus.fifo_cnt, 3'd0);

    // asynchronous reset mid-cycle with a part-full queue
    do_reset();
    bus.key_flag = 6'b001111;
    step(1);
    bus.key_flag = '0;
    step(3);
    chk("s5_cnt_pre", bus.fifo_cnt, 3'd3);
    chk("s5_pend_pre", bus.pend, 6'b001000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_valid_rst", bus.evt_valid, 1'b0);
    chk("s5_cnt_rst", bus.fifo_cnt, 3'd0);
    chk("s5_pend_rst", bus.pend, 6'd0);
    chk("s5_code_rst", bus.evt_code, 3'd0);
    chk("s5_ovf_rst", bus.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    single_press("s5");

    // head held stable under backpressure while another key queues
    do_reset();
    bus.key_flag = 6'b000001;
    step(1);
    bus.key_flag = '0;
    step(1);
    chk("s6_valid", bus.evt_valid, 1'b1);
    chk("s6_cnt1", bus.fifo_cnt, 3'd1);
    bus.key_flag = 6'b000010;
    step(1);
    bus.key_flag = '0;
    for (int i = 0; i < 10; i++) begin
      chk("s6_code_hold", bus.evt_code, 3'd0);
      step(1);
    end
    chk("s6_cnt2", bus.fifo_cnt, 3'd2);
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    bus.evt_ready = 1'b1;
    drain(20);
    step(1);
    chk("s6_cnt_empty", bus.fifo_cnt, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
